adc_pots_spi_model: RTL and testbench

- Synthesizable model of an 8-channel 12-bit SPI A2D converter (ADC128S-style) with six slide-pot inputs.
- Sits on the equalizer board-level bench; the equalizer's SPI master reads pot settings (LP, B1, B2, B3, HP, VOL) through it.
- Pot values are driven directly as 12-bit ports.
- Each 16-bit SPI transaction returns the conversion requested by the previous transaction.

---
 rtl/adc_pots_spi_model.sv | 130 +++++++++++++
 tb/tb_adc_pots_spi_model.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/adc_pots_spi_model.sv
// SPI A2D (ADC128S-style) model returning six slide-pot positions; each frame returns the previous command's conversion.
// Define ADC_CONV_CNT_EN to add the conv_cnt output counting completed conversions.
module adc_pots_spi_model #(
  parameter logic [11:0] RST_RESULT  = 12'h000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [11:0] LP,
  input  logic [11:0] B1,
  input  logic [11:0] B2,
  input  logic [11:0] B3,
  input  logic [11:0] HP,
  input  logic [11:0] VOL
`ifdef ADC_CONV_CNT_EN
  ,
  output logic [15:0] conv_cnt
`endif
);

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_prev;
  logic                   r_ss_prev;
  logic [15:0]            r_tx_shft;
  // Only the low 14 bits of the received frame can ever reach the channel field.
  logic [13:0]            r_rx_shft;
  logic [4:0]             r_bit_cnt;
  logic [11:0]            r_result;
  logic [11:0]            r_sample;
  logic                   r_upd;
`ifdef ADC_CONV_CNT_EN
  logic [15:0]            r_conv_cnt;
`endif

  logic        w_sclk_cur;
  logic        w_ss_cur;
  logic        w_mosi;
  logic        w_sclk_rise;
  logic        w_sclk_fall;
  logic        w_ss_fall;
  logic        w_ss_rise;
  logic [11:0] w_pot;

  assign w_sclk_cur  = r_sclk_sync[SYNC_STAGES-1];
  assign w_ss_cur    = r_ss_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_cur & ~r_sclk_prev;
  assign w_sclk_fall = ~w_sclk_cur & r_sclk_prev;
  assign w_ss_fall   = ~w_ss_cur & r_ss_prev;
  assign w_ss_rise   = w_ss_cur & ~r_ss_prev;

  // Gated by the delayed select so the stale shifter is never visible during the load cycle.
  assign MISO = ~r_ss_prev & r_tx_shft[15];

  always_comb begin
    w_pot = 12'h000;
    case (r_rx_shft[13:11])
      3'd0:    w_pot = B1;
      3'd1:    w_pot = LP;
      3'd2:    w_pot = B3;
      3'd3:    w_pot = HP;
      3'd4:    w_pot = B2;
      3'd7:    w_pot = VOL;
      default: w_pot = 12'h000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_sync <= '0;
      r_ss_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_prev <= 1'b0;
      r_ss_prev   <= 1'b1;
      r_tx_shft   <= '0;
      r_rx_shft   <= '0;
      r_bit_cnt   <= '0;
      r_result    <= RST_RESULT;
      r_sample    <= '0;
      r_upd       <= 1'b0;
`ifdef ADC_CONV_CNT_EN
      r_conv_cnt  <= '0;
`endif
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], SS_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
      r_sclk_prev <= w_sclk_cur;
      r_ss_prev   <= w_ss_cur;
      r_upd       <= 1'b0;

      if (w_ss_fall) begin
        r_tx_shft <= {4'b0000, r_result};
        r_bit_cnt <= '0;
      end else if (!w_ss_cur) begin
        if (w_sclk_rise) begin
          r_rx_shft <= {r_rx_shft[12:0], w_mosi};
          if (r_bit_cnt != 5'd16)
            r_bit_cnt <= r_bit_cnt + 5'd1;
        end
        if (w_sclk_fall && r_bit_cnt != 5'd0)
          r_tx_shft <= {r_tx_shft[14:0], 1'b0};
      end

      // Pots are sampled at the conversion instant; result follows one clk later.
      if (w_ss_rise && r_bit_cnt == 5'd16) begin
        r_sample <= w_pot;
        r_upd    <= 1'b1;
      end

      if (r_upd) begin
        r_result <= r_sample;
`ifdef ADC_CONV_CNT_EN
        r_conv_cnt <= r_conv_cnt + 16'd1;
`endif
      end
    end
  end

`ifdef ADC_CONV_CNT_EN
  assign conv_cnt = r_conv_cnt;
`endif

endmodule

// File: tb/tb_adc_pots_spi_model.sv
// Self-checking bench for adc_pots_spi_model: directed scenarios plus randomized frames against a frame-level model.
module tb_adc_pots_spi_model;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  wire         MISO;
  logic [11:0] LP, B1, B2, B3, HP, VOL;
`ifdef ADC_CONV_CNT_EN
  logic [15:0] conv_cnt;
`endif

  adc_pots_spi_model dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .LP(LP), .B1(B1), .B2(B2), .B3(B3), .HP(HP), .VOL(VOL)
`ifdef ADC_CONV_CNT_EN
    , .conv_cnt(conv_cnt)
`endif
  );

  always #5 clk = ~clk;

  localparam int PH = 10;
  int          errors = 0;
  int          checks = 0;
  logic [11:0] m_result;
  int          m_cnt;

  function automatic logic [11:0] pot_of(input logic [2:0] ch);
    logic [11:0] tbl [8];
    tbl = '{B1, LP, B3, HP, B2, 12'h000, 12'h000, VOL};
    return tbl[ch];
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends bits[n-1:0] MSB first; rd collects the first 16 MISO bits sampled before each rise.
  task automatic xfer(input logic [31:0] bits, input int n, output logic [15:0] rd);
    rd   = '0;
    SS_n = 1'b0;
    wait_clk(PH);
    for (int i = n - 1; i >= 0; i--) begin
      MOSI = bits[i];
      wait_clk(PH);
      if (n - 1 - i < 16) rd = {rd[14:0], MISO};
      SCLK = 1'b1;
      wait_clk(PH);
      SCLK = 1'b0;
    end
    wait_clk(PH);
    SS_n = 1'b1;
    if (n >= 16) begin
      m_result = pot_of(bits[13:11]);
      m_cnt++;
    end
    wait_clk(2 * PH);
    MOSI = 1'b0;
  endtask

  task automatic test_reset;
    logic [15:0] rd;
    rst_n = 1'b0; SS_n = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
    {LP, B1, B2, B3, HP, VOL} = '0;
    wait_clk(3);
    checks++;
    if (MISO !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b want 0", MISO); end
    rst_n = 1'b1;
    m_result = 12'h000; m_cnt = 0;
    wait_clk(3);
`ifdef ADC_CONV_CNT_EN
    checks++;
    if (conv_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", conv_cnt); end
`endif
    xfer(32'h0800, 16, rd);
    checks++;
    if (rd !== 16'h0000) begin errors++; $display("FAIL first_read: got %h want 0000", rd); end
  endtask

  task automatic test_lp_vol;
    logic [15:0] rd;
    logic [15:0] exp;
    LP = 12'd2048; VOL = 12'd2048;
    xfer(32'h0800, 16, rd);
    xfer(32'h3800, 16, rd);
    checks++;
    if (rd !== 16'h0800) begin errors++; $display("FAIL lp_read: got %h want 0800", rd); end
    exp = {4'h0, m_result};
    xfer($urandom, 16, rd);
    checks++;
    if (rd !== exp || exp !== 16'h0800) begin errors++; $display("FAIL vol_read: got %h want 0800", rd); end
  endtask

  task automatic test_sweep;
    logic [15:0] rd;
    logic [15:0] exp_seq [8];
    exp_seq = '{16'h0111, 16'h0222, 16'h0333, 16'h0444, 16'h0555, 16'h0000, 16'h0000, 16'h0FFF};
    B1 = 12'h111; LP = 12'h222; B3 = 12'h333; HP = 12'h444; B2 = 12'h555; VOL = 12'hFFF;
    xfer(32'h0000, 16, rd);
    for (int ch = 1; ch <= 8; ch++) begin
      xfer({16'h0, 2'b00, 3'(ch % 8), 11'h0}, 16, rd);
      checks++;
      if (rd !== exp_seq[ch - 1]) begin
        errors++; $display("FAIL sweep_ch%0d: got %h want %h", ch - 1, rd, exp_seq[ch - 1]);
      end
    end
  endtask

  task automatic test_idle_sclk;
    logic [15:0] rd;
    logic [15:0] exp;
    exp = {4'h0, m_result};
    for (int i = 0; i < 4; i++) begin
      MOSI = 1'b1; SCLK = 1'b1; wait_clk(PH);
      checks++;
      if (MISO !== 1'b0) begin errors++; $display("FAIL idle_miso: got %b want 0", MISO); end
      SCLK = 1'b0; wait_clk(PH);
    end
    xfer(32'h1800, 16, rd);
    checks++;
    if (rd !== exp) begin errors++; $display("FAIL idle_result: got %h want %h", rd, exp); end
  endtask

  task automatic test_abort;
    logic [15:0] rd;
    logic [15:0] exp;
    B2 = 12'h5A5;
    xfer(32'h2000, 16, rd);
    exp = {4'h0, m_result};
`ifdef ADC_CONV_CNT_EN
    checks++;
    if (conv_cnt !== 16'(m_cnt)) begin errors++; $display("FAIL cnt_pre_abort: got %0d want %0d", conv_cnt, m_cnt); end
`endif
    xfer(32'h3800 >> 7, 9, rd);
`ifdef ADC_CONV_CNT_EN
    checks++;
    if (conv_cnt !== 16'(m_cnt)) begin errors++; $display("FAIL cnt_abort: got %0d want %0d", conv_cnt, m_cnt); end
`endif
    xfer(32'h0000, 16, rd);
    checks++;
    if (rd !== exp || exp !== 16'h05A5) begin errors++; $display("FAIL abort_read: got %h want 05a5", rd); end
  endtask

  task automatic test_sample_time;
    logic [15:0] rd;
    LP = 12'h100;
    xfer(32'h0800, 16, rd);
    LP = 12'h200;
    xfer(32'h0800, 16, rd);
    checks++;
    if (rd !== 16'h0100) begin errors++; $display("FAIL sample_time: got %h want 0100", rd); end
  endtask

  task automatic test_reset_mid;
    logic [15:0] rd;
    HP = 12'hABC;
    xfer(32'h1800, 16, rd);
    SS_n = 1'b0;
    wait_clk(PH);
    for (int i = 0; i < 4; i++) begin
      MOSI = 1'b1; wait_clk(PH);
      SCLK = 1'b1; wait_clk(PH);
      SCLK = 1'b0;
    end
    wait_clk(PH);
    checks++;
    if (MISO !== 1'b1) begin errors++; $display("FAIL mid_bit11: got %b want 1", MISO); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (MISO !== 1'b0) begin errors++; $display("FAIL mid_reset_miso: got %b want 0", MISO); end
    SS_n = 1'b1; MOSI = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    m_result = 12'h000; m_cnt = 0;
    wait_clk(3);
    xfer(32'h1800, 16, rd);
    checks++;
    if (rd !== 16'h0000) begin errors++; $display("FAIL post_reset_read: got %h want 0000", rd); end
  endtask

  task automatic test_random;
    logic [15:0] rd;
    logic [15:0] exp;
    logic [31:0] bits;
    int          n;
    int          kind;
    for (int it = 0; it < 24; it++) begin
      {LP, B1, B2, B3} = {12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom)};
      {HP, VOL}        = {12'($urandom), 12'($urandom)};
      kind = $urandom_range(0, 5);
      n    = (kind == 0) ? $urandom_range(1, 15) : (kind == 1) ? $urandom_range(17, 20) : 16;
      bits = $urandom;
      exp  = {4'h0, m_result};
      xfer(bits, n, rd);
      if (n >= 16) begin
        checks++;
        if (rd !== exp) begin errors++; $display("FAIL rand_%0d n=%0d: got %h want %h", it, n, rd, exp); end
      end
    end
    exp = {4'h0, m_result};
    xfer(32'h0, 16, rd);
    checks++;
    if (rd !== exp) begin errors++; $display("FAIL rand_final: got %h want %h", rd, exp); end
`ifdef ADC_CONV_CNT_EN
    checks++;
    if (conv_cnt !== 16'(m_cnt)) begin errors++; $display("FAIL rand_cnt: got %0d want %0d", conv_cnt, m_cnt); end
`endif
  endtask

  initial begin
    test_reset;
    test_lp_vol;
    test_sweep;
    test_idle_sclk;
    test_abort;
    test_sample_time;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
